// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the register-file command sequencer.
// Imported by regfile_sequencer and regfile_seq_alu.
package regfile_seq_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 16;
    localparam int unsigned DEFAULT_INDEX_WIDTH = 2;

    typedef enum logic [1:0] {
        OP_LOADI = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_MOV   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ_A = 2'd1,
        ST_READ_B = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational result datapath for the sequencer: picks imm/opA or forms
// opA+opB / opA-opB, plus carry-out (ADD) or borrow (SUB).
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);

    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] diff;

    always_comb begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        diff    = op_a - op_b;
        result  = '0;
        carry   = 1'b0;
        case (op)
            OP_LOADI: result = imm;
            OP_MOV:   result = op_a;
            OP_ADD: begin
                result = sum_ext[DATA_WIDTH-1:0];
                carry  = sum_ext[DATA_WIDTH];
            end
            OP_SUB: begin
                result = diff;
                carry  = (op_a < op_b);
            end
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer mastering a 1R/1W register file: accept, read up to two
// operands, compute, write. Optional flags via macro REGFILE_SEQ_FLAGS_EN.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [INDEX_WIDTH-1:0] cmd_dst,
    input  logic [INDEX_WIDTH-1:0] cmd_src_a,
    input  logic [INDEX_WIDTH-1:0] cmd_src_b,
    input  logic [DATA_WIDTH-1:0]  cmd_imm,
    output logic [INDEX_WIDTH-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]  rf_read_data,
    output logic [INDEX_WIDTH-1:0] rf_write_index,
    output logic                   rf_write_enable,
    output logic [DATA_WIDTH-1:0]  rf_write_data,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic                   flag_zero,
    output logic                   flag_carry
`endif
);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [INDEX_WIDTH-1:0] dst_q, dst_d;
    logic [INDEX_WIDTH-1:0] src_a_q, src_a_d;
    logic [INDEX_WIDTH-1:0] src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0]  imm_q, imm_d;
    logic [DATA_WIDTH-1:0]  opa_q, opa_d;
    logic [DATA_WIDTH-1:0]  opb_q, opb_d;

    logic [DATA_WIDTH-1:0]  alu_result;
    logic                   in_write;
`ifdef REGFILE_SEQ_FLAGS_EN
    logic                   alu_carry;
`else
    logic                   alu_carry_unused;
`endif

    regfile_seq_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op     (op_q),
        .op_a   (opa_q),
        .op_b   (opb_q),
        .imm    (imm_q),
        .result (alu_result),
`ifdef REGFILE_SEQ_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  (alu_carry_unused)
`endif
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        imm_d   = imm_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    dst_d   = cmd_dst;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    imm_d   = cmd_imm;
                    state_d = (op_e'(cmd_op) == OP_LOADI) ? ST_WRITE : ST_READ_A;
                end
            end
            ST_READ_A: begin
                opa_d   = rf_read_data;
                state_d = (op_q == OP_MOV) ? ST_WRITE : ST_READ_B;
            end
            ST_READ_B: begin
                opb_d   = rf_read_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
        endcase
    end

    // Write-side outputs are gated by reset so an aborted command never commits.
    always_comb begin
        in_write        = (state_q == ST_WRITE) && !reset;
        cmd_ready       = (state_q == ST_IDLE) && !reset;
        rf_read_index   = '0;
        if (state_q == ST_READ_A) rf_read_index = src_a_q;
        if (state_q == ST_READ_B) rf_read_index = src_b_q;
        rf_write_enable = in_write;
        done            = in_write;
        rf_write_index  = in_write ? dst_q : '0;
        rf_write_data   = in_write ? alu_result : '0;
        result          = in_write ? alu_result : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOADI;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            imm_q   <= imm_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

`ifdef REGFILE_SEQ_FLAGS_EN
    logic flag_zero_q, flag_zero_d;
    logic flag_carry_q, flag_carry_d;

    always_comb begin
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        if (state_q == ST_WRITE) begin
            flag_zero_d  = (alu_result == '0);
            flag_carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: behavioural register file plus an
// array-based reference model; directed cases then randomized commands.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_dst, cmd_src_a, cmd_src_b;
    logic [15:0] cmd_imm;
    logic [1:0]  rf_read_index;
    logic [15:0] rf_read_data;
    logic [1:0]  rf_write_index;
    logic        rf_write_enable;
    logic [15:0] rf_write_data;
    logic        done;
    logic [15:0] result;
`ifdef REGFILE_SEQ_FLAGS_EN
    logic        flag_zero, flag_carry;
    logic        ref_zero, ref_carry;
`endif

    int total = 0;
    int bad   = 0;
    int we_count = 0;
    int exp_writes = 0;
    logic [15:0] rf_mem [4];
    logic [15:0] ref_rf [4];

    always #5 clk = ~clk;

    regfile_sequencer #(
        .DATA_WIDTH(16),
        .INDEX_WIDTH(2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_dst         (cmd_dst),
        .cmd_src_a       (cmd_src_a),
        .cmd_src_b       (cmd_src_b),
        .cmd_imm         (cmd_imm),
        .rf_read_index   (rf_read_index),
        .rf_read_data    (rf_read_data),
        .rf_write_index  (rf_write_index),
        .rf_write_enable (rf_write_enable),
        .rf_write_data   (rf_write_data),
        .done            (done),
        .result          (result)
`ifdef REGFILE_SEQ_FLAGS_EN
        ,
        .flag_zero       (flag_zero),
        .flag_carry      (flag_carry)
`endif
    );

    // Register file environment: combinational read, clears on reset.
    assign rf_read_data = rf_mem[rf_read_index];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 16'h0;
        end else if (rf_write_enable) begin
            rf_mem[rf_write_index] <= rf_write_data;
        end
        if (rf_write_enable) we_count <= we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) ref_rf[i] = 16'h0;
`ifdef REGFILE_SEQ_FLAGS_EN
        ref_zero  = 1'b0;
        ref_carry = 1'b0;
`endif
    endtask

    task automatic scramble_inputs();
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_dst   = 2'($urandom_range(0, 3));
        cmd_src_a = 2'($urandom_range(0, 3));
        cmd_src_b = 2'($urandom_range(0, 3));
        cmd_imm   = 16'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                           input logic [1:0] b, input logic [15:0] imm, input bit scramble,
                           input bit keep_valid, output int waits);
        int unsigned va, vb, exp_val;
        int exp_lat, lat;
        bit exp_cy, got;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
        cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("accept_ready", cmd_ready, 1);
        va = ref_rf[a];
        vb = ref_rf[b];
        exp_cy = 1'b0;
        case (op)
            2'd0: begin exp_val = imm; exp_lat = 1; end
            2'd1: begin exp_val = (va + vb) % 65536; exp_cy = (va + vb) > 65535; exp_lat = 3; end
            2'd2: begin exp_val = (va + 65536 - vb) % 65536; exp_cy = (va < vb); exp_lat = 3; end
            default: begin exp_val = va; exp_lat = 2; end
        endcase
        @(posedge clk); #1;
        if (!scramble) cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            check("busy_not_ready", cmd_ready, 0);
            if (scramble) scramble_inputs();
            if (done) begin
                got = 1'b1;
            end else begin
                check("early_we", rf_write_enable, 0);
                if (op != 2'd0 && lat == 1) check("read_idx_a", rf_read_index, a);
                if ((op == 2'd1 || op == 2'd2) && lat == 2) check("read_idx_b", rf_read_index, b);
            end
        end
        check("done_seen", got, 1);
        check("latency", lat, exp_lat);
        check("write_en", rf_write_enable, 1);
        check("write_idx", rf_write_index, dst);
        check("write_data", rf_write_data, exp_val);
        check("result", result, exp_val);
        if (!keep_valid) cmd_valid = 1'b0;
        ref_rf[dst] = 16'(exp_val);
        exp_writes++;
`ifdef REGFILE_SEQ_FLAGS_EN
        ref_zero  = (exp_val == 0);
        ref_carry = exp_cy;
`endif
        @(posedge clk); #1;
        check("post_done", done, 0);
        check("post_result", result, 0);
        check("rf_commit", rf_mem[dst], exp_val);
`ifdef REGFILE_SEQ_FLAGS_EN
        check("flag_zero", flag_zero, ref_zero);
        check("flag_carry", flag_carry, ref_carry);
`else
        check("carry_model", exp_cy, exp_cy);
`endif
    endtask

    initial begin
        int w;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dst = 2'd0;
        cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 16'h0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_we", rf_write_enable, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_rd_idx", rf_read_index, 0);
        check("idle_wr_idx", rf_write_index, 0);
        check("idle_wr_data", rf_write_data, 0);
`ifdef REGFILE_SEQ_FLAGS_EN
        check("rst_flag_zero", flag_zero, 0);
        check("rst_flag_carry", flag_carry, 0);
`endif

        run_cmd(2'd0, 2'd2, 2'd0, 2'd0, 16'h1234, 1'b0, 1'b0, w);
        check("reg2_loaded", rf_mem[2], 16'h1234);
        run_cmd(2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 1'b0, 1'b0, w);
        run_cmd(2'd0, 2'd1, 2'd0, 2'd0, 16'h0002, 1'b0, 1'b0, w);
        run_cmd(2'd1, 2'd3, 2'd0, 2'd1, 16'h0000, 1'b0, 1'b0, w);
        check("add_wrap", rf_mem[3], 16'h0001);
        run_cmd(2'd0, 2'd0, 2'd0, 2'd0, 16'h00AA, 1'b0, 1'b0, w);
        run_cmd(2'd2, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, w);
        check("sub_self_zero", rf_mem[0], 16'h0000);

        // MOV then ADD with cmd_valid held high across the boundary.
        run_cmd(2'd3, 2'd1, 2'd3, 2'd0, 16'h0000, 1'b0, 1'b1, w);
        run_cmd(2'd1, 2'd2, 2'd1, 2'd1, 16'h0000, 1'b0, 1'b0, w);
        check("b2b_no_wait", w, 0);
        check("add_twice_r3", rf_mem[2], 16'h0002);

        // Abort an ADD with reset during READ_B.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 2'd2; cmd_src_a = 2'd1; cmd_src_b = 2'd3;
        check("abort_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_rd_a", rf_read_index, 1);
        @(negedge clk);
        check("abort_rd_b", rf_read_index, 3);
        reset = 1'b1;
        #1;
        check("abort_rst_ready", cmd_ready, 0);
        check("abort_rst_we", rf_write_enable, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        #1;
        check("abort_idle_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done, 0);
            check("abort_no_we", rf_write_enable, 0);
            @(negedge clk);
        end
        check("abort_write_count", we_count, exp_writes);
        for (int i = 0; i < 4; i++) check("rf_cleared", rf_mem[i], 0);
`ifdef REGFILE_SEQ_FLAGS_EN
        check("abort_flag_zero", flag_zero, 0);
`endif

        // Randomized commands, sometimes with busy-time input churn.
        for (int n = 0; n < 40; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), w);
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("final_write_count", we_count, exp_writes);
        for (int i = 0; i < 4; i++) check("final_rf", rf_mem[i], ref_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
